wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter between the execute/memory pipeline and the register file write port. It merges single-cycle pipeline results with results from long-latency units (multiplier/divider), which are buffered in a small FIFO. It drives the register file's `write_enable`, `Destination_select` and `DATA` from registered outputs. A starvation guard ensures buffered long results eventually win the single write port.

## Interface
- `WIDTH`, 32: data width.
- `DEPTH`, 4: long-result FIFO entries; must be a power of 2, ≥2.
- `STARVE_LIMIT`, 4: blocked cycles before the FIFO head takes priority; range 1..15.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pipe_we`  in  1  pipeline writeback request this cycle.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  WIDTH  pipeline result.
- `long_valid`  in  1  long-latency result offered.
- `long_rd`  in  5  long-result destination.
- `long_data`  in  WIDTH  long result.
- `long_ready`  out  1  FIFO can accept; equals !full.
- `pipe_stall`  out  1  pipeline must hold its writeback; `pipe_we` must be 0 while high.
- `write_enable`  out  1  register file write strobe.
- `Destination_select`  out  5  register file write address.
- `DATA`  out  WIDTH  register file write data.
- `pending`  out  1  FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Long accept: a handshake occurs when `long_valid && long_ready`. Entries with `long_rd==0` complete the handshake but are not enqueued.
- `long_ready` depends only on occupancy. A pop in the same cycle does not free a slot early.
- Pipeline request is effective when `pipe_we && pipe_rd!=0`; a write to x0 is a no-request.
- Grant order each cycle:
  1. If `pipe_stall`, pop the FIFO head.
  2. Otherwise, an effective pipeline request wins.
  3. Otherwise, pop the FIFO head if non-empty.
  4. Otherwise, idle.
- Output register load:
  - On a grant: `write_enable`=1, with `Destination_select` and `DATA` from the winner.
  - When idle: `write_enable`=0; `Destination_select` and `DATA` hold their last values.
- Starve counter (4 bits):
  - Cleared on a pop or when the FIFO is empty.
  - Otherwise increments at each edge, saturating at `STARVE_LIMIT`.
  - `pipe_stall` = (counter == `STARVE_LIMIT`), decoded from the register.
- Simultaneous push and pop: occupancy unchanged; FIFO order preserved strictly.
- A push into an empty FIFO cannot be popped in the same cycle; the head is visible from the next cycle.
- Reset (asynchronous, any time):
  - FIFO pointers, `count` and starve counter go to 0, discarding queued results.
  - `write_enable`=0, `Destination_select`=0, `DATA`=0, `pipe_stall`=0, `pending`=0, `long_ready`=1.
- Protocol violation: `pipe_we` high while `pipe_stall` is high. The pipeline request is ignored, and a bench assertion flags it.

## Timing
- Pipeline result to `write_enable`: 1 cycle (registered). The register file captures on the falling edge of that same cycle.
- Long result, FIFO empty and no pipeline traffic: accepted at edge E0, popped at E1, `write_enable` high after E1.
- Worst case with continuous pipeline traffic:
  - Head blocked at edges E1..E`STARVE_LIMIT`.
  - `pipe_stall` high after E`STARVE_LIMIT`.
  - Pop at the next edge, then `pipe_stall` drops.
  - Total latency: `STARVE_LIMIT`+1 cycles after the head reaches the FIFO front.
- `long_ready`, `pending`, `count` and `pipe_stall` update only on clock edges, except for reset.

## Test plan
- Reset: hold `reset`=0 mid-traffic with 3 queued entries → all outputs at reset values immediately (before the next edge); `count`=0 and `long_ready`=1 after release.
- Pipeline only: `pipe_we`=1, `pipe_rd`=5, `pipe_data`=0xDEADBEEF at edge N → `write_enable`=1, `Destination_select`=5, `DATA`=0xDEADBEEF after N. With `pipe_rd`=0 → `write_enable`=0.
- FIFO fill and order: push rd 1..4, data 0x11..0x44, with `pipe_we` continuously high to rd 7 and `STARVE_LIMIT`=15 → `long_ready`=0 at `count`=4. A fifth offer is held off. Drop `pipe_we` → writes to rd 1,2,3,4 in order on consecutive cycles.
- Starvation (`STARVE_LIMIT`=4): push rd 9 / 0xCAFE at E0 with `pipe_we` high every cycle → `pipe_stall` high after E4, then rd 9 written after E5 and `pipe_stall` low after E5.
- Simultaneous push/pop at `count`=2 → `count` stays 2 and output data order matches push order. A long result with rd 0 → handshake completes and `count` is unchanged.
- Reset mid-stall: `pipe_stall`=1 with `count`=3, assert reset → `pipe_stall`=0 and `count`=0; the first post-reset write comes from the pipeline.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle pipeline results with buffered long-latency
// results onto one registered register-file write port, with a starvation guard.
module wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_rd,
  input  logic [WIDTH-1:0]         pipe_data,
  input  logic                     long_valid,
  input  logic [4:0]               long_rd,
  input  logic [WIDTH-1:0]         long_data,
  output logic                     long_ready,
  output logic                     pipe_stall,
  output logic                     write_enable,
  output logic [4:0]               Destination_select,
  output logic [WIDTH-1:0]         DATA,
  output logic                     pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);

  logic [4:0]       rd_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [3:0]       starve;

  logic empty;
  logic full;
  logic pipe_grant;
  logic pop;
  logic push;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign long_ready = !full;
  assign pending    = !empty;
  assign pipe_stall = (starve == LIMIT);

  // A stalled pipeline never wins, so the head pops whenever the pipeline is not granted.
  assign pipe_grant = pipe_we && (pipe_rd != 5'd0) && !pipe_stall;
  assign pop        = !empty && !pipe_grant;
  // x0 results complete the handshake but carry nothing worth writing.
  assign push       = long_valid && long_ready && (long_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= long_rd;
      data_mem[wr_ptr] <= long_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (pop || empty) begin
      starve <= '0;
    end else if (starve != LIMIT) begin
      starve <= starve + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable       <= 1'b0;
      Destination_select <= '0;
      DATA               <= '0;
    end else if (pipe_grant) begin
      write_enable       <= 1'b1;
      Destination_select <= pipe_rd;
      DATA               <= pipe_data;
    end else if (pop) begin
      write_enable       <= 1'b1;
      Destination_select <= rd_mem[rd_ptr];
      DATA               <= data_mem[rd_ptr];
    end else begin
      write_enable       <= 1'b0;
    end
  end

endmodule
